// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
//   Shares one AXI4-Lite style memory read port between instruction fetch (im)
//   and the load path (dm). Only one transaction is outstanding at a time.
//   When both requesters are valid in IDLE, the one that did not win last time
//   is granted (round-robin). The response is routed to the granted requester.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   i_im_* / o_im_*           fetch read channel (AR + R)
//   i_dm_* / o_dm_*           load read channel (AR + R)
//   o_mem_* / i_mem_*         unified memory read port (AR + R)
//   o_mem_arprot              bit2 = instruction access, bits1:0 = 0
//   o_grant                   current owner, 0 = fetch, 1 = load
// -----------------------------------------------------------------------------
module mem_read_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,

   input  logic            i_im_arvalid,
   output logic            o_im_arready,
   input  logic [XLEN-1:0] i_im_araddr,
   output logic            o_im_rvalid,
   input  logic            i_im_rready,
   output logic [XLEN-1:0] o_im_rdata,
   output logic [1:0]      o_im_rresp,

   input  logic            i_dm_arvalid,
   output logic            o_dm_arready,
   input  logic [XLEN-1:0] i_dm_araddr,
   output logic            o_dm_rvalid,
   input  logic            i_dm_rready,
   output logic [XLEN-1:0] o_dm_rdata,
   output logic [1:0]      o_dm_rresp,

   output logic            o_mem_arvalid,
   input  logic            i_mem_arready,
   output logic [XLEN-1:0] o_mem_araddr,
   output logic [2:0]      o_mem_arprot,
   input  logic            i_mem_rvalid,
   output logic            o_mem_rready,
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic [1:0]      i_mem_rresp,

   output logic            o_grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   state_e          state_q;
   logic            grant_q;
   logic            last_grant_q;
   logic [XLEN-1:0] addr_q;
   logic [2:0]      prot_q;

   logic idle_ok;
   logic pick_dm;
   logic accept;
   logic in_data;

   // Arbitration is only live in IDLE and outside reset, so no requester ever
   // sees arready while a transaction is outstanding or while being reset.
   assign idle_ok = rstn && (state_q == IDLE);

   // Load wins when it is the only requester, or on a tie when fetch won last.
   assign pick_dm = i_dm_arvalid && (!i_im_arvalid || !last_grant_q);
   assign accept  = idle_ok && (i_im_arvalid || i_dm_arvalid);

   assign o_im_arready = idle_ok && i_im_arvalid && !pick_dm;
   assign o_dm_arready = idle_ok && pick_dm;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;  // fetch wins the first tie after reset
         addr_q       <= '0;
         prot_q       <= 3'b000;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q       <= pick_dm ? i_dm_araddr : i_im_araddr;
                  prot_q       <= {~pick_dm, 2'b00};
                  grant_q      <= pick_dm;
                  last_grant_q <= pick_dm;
                  state_q      <= ADDR;
               end
            end
            ADDR: begin
               if (i_mem_arready) state_q <= DATA;
            end
            DATA: begin
               if (i_mem_rvalid && o_mem_rready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Address channel comes straight from the captured registers, so later
   // changes on the requester address inputs cannot disturb it.
   assign o_mem_arvalid = (state_q == ADDR);
   assign o_mem_araddr  = addr_q;
   assign o_mem_arprot  = prot_q;

   // Read data path is purely combinational: zero added latency.
   assign in_data      = (state_q == DATA);
   assign o_mem_rready = in_data && (grant_q ? i_dm_rready : i_im_rready);

   assign o_im_rvalid = in_data && !grant_q && i_mem_rvalid;
   assign o_dm_rvalid = in_data &&  grant_q && i_mem_rvalid;

   // Data and response are broadcast; rvalid alone qualifies them per port.
   assign o_im_rdata = i_mem_rdata;
   assign o_im_rresp = i_mem_rresp;
   assign o_dm_rdata = i_mem_rdata;
   assign o_dm_rresp = i_mem_rresp;

   assign o_grant = grant_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_read_arbiter
//   Directed bench for mem_read_arbiter. Each accepted request pushes an
//   expected entry (owner, address, prot, response) into a queue; the entry is
//   compared on the memory address channel and popped when the response
//   handshake is seen on the owning requester port.
// -----------------------------------------------------------------------------
module tb_mem_read_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rstn;
   logic            i_im_arvalid, o_im_arready, o_im_rvalid, i_im_rready;
   logic [XLEN-1:0] i_im_araddr, o_im_rdata;
   logic [1:0]      o_im_rresp;
   logic            i_dm_arvalid, o_dm_arready, o_dm_rvalid, i_dm_rready;
   logic [XLEN-1:0] i_dm_araddr, o_dm_rdata;
   logic [1:0]      o_dm_rresp;
   logic            o_mem_arvalid, i_mem_arready, i_mem_rvalid, o_mem_rready;
   logic [XLEN-1:0] o_mem_araddr, i_mem_rdata;
   logic [2:0]      o_mem_arprot;
   logic [1:0]      i_mem_rresp;
   logic            o_grant;

   always #5 clk = ~clk;

   mem_read_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .rstn(rstn),
      .i_im_arvalid(i_im_arvalid), .o_im_arready(o_im_arready),
      .i_im_araddr(i_im_araddr), .o_im_rvalid(o_im_rvalid),
      .i_im_rready(i_im_rready), .o_im_rdata(o_im_rdata), .o_im_rresp(o_im_rresp),
      .i_dm_arvalid(i_dm_arvalid), .o_dm_arready(o_dm_arready),
      .i_dm_araddr(i_dm_araddr), .o_dm_rvalid(o_dm_rvalid),
      .i_dm_rready(i_dm_rready), .o_dm_rdata(o_dm_rdata), .o_dm_rresp(o_dm_rresp),
      .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
      .o_mem_araddr(o_mem_araddr), .o_mem_arprot(o_mem_arprot),
      .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
      .i_mem_rdata(i_mem_rdata), .i_mem_rresp(i_mem_rresp),
      .o_grant(o_grant)
   );

   typedef struct {
      logic            port;   // 0 = fetch, 1 = load
      logic [XLEN-1:0] addr;
      logic [2:0]      prot;
      logic [1:0]      resp;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;
   bit   exp_last;             // round-robin model: owner of the last grant

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Memory contents model.
   function automatic logic [XLEN-1:0] mem_data(input logic [XLEN-1:0] a);
      return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
   endfunction

   // Inputs are driven 1 time unit after the rising edge and outputs are
   // sampled a further unit later, well away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      i_im_arvalid  = 1'b0;
      i_dm_arvalid  = 1'b0;
      i_im_rready   = 1'b0;
      i_dm_rready   = 1'b0;
      i_mem_arready = 1'b0;
      i_mem_rvalid  = 1'b0;
      i_mem_rdata   = '0;
      i_mem_rresp   = 2'b00;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      tick();
      settle();
      check("rst_mem_arvalid", o_mem_arvalid, 0);
      check("rst_mem_rready", o_mem_rready, 0);
      check("rst_im_rvalid", o_im_rvalid, 0);
      check("rst_dm_rvalid", o_dm_rvalid, 0);
      check("rst_grant", o_grant, 0);
      check("rst_araddr", o_mem_araddr, 0);
      check("rst_arprot", o_mem_arprot, 0);
      rstn = 1'b1;
      exp_last = 1'b1;
      sb.delete();
   endtask

   // One full transaction starting in an IDLE cycle.
   //   im_v/dm_v  : arvalids presented in the accept cycle
   //   ar_stall   : cycles i_mem_arready stays low in ADDR
   //   rv_wait    : cycles before the memory raises rvalid
   //   rr_wait    : cycles the owner holds rready low while rvalid is high
   //   hold       : keep both arvalids high for the whole transaction
   task automatic do_txn(input bit im_v, input bit dm_v, input int ar_stall,
                         input int rv_wait, input int rr_wait,
                         input logic [1:0] resp, input bit hold, output bit win);
      exp_t e, p;
      i_im_arvalid  = im_v;
      i_dm_arvalid  = dm_v;
      i_mem_arready = 1'b0;
      i_mem_rvalid  = 1'b0;
      i_im_rready   = 1'b0;
      i_dm_rready   = 1'b0;
      win = dm_v && (!im_v || (exp_last == 1'b0));
      settle();
      check("acc_im_arready", o_im_arready, im_v && !win);
      check("acc_dm_arready", o_dm_arready, win);
      check("acc_mem_arvalid", o_mem_arvalid, 0);
      e.port = win;
      e.addr = win ? i_dm_araddr : i_im_araddr;
      e.prot = win ? 3'b000 : 3'b100;
      e.resp = resp;
      sb.push_back(e);
      exp_last = win;
      tick();

      // Requester moves on: its address input changes right after acceptance.
      if (!hold) begin
         i_im_arvalid = 1'b0;
         i_dm_arvalid = 1'b0;
      end
      if (win) i_dm_araddr = i_dm_araddr + 32'h1000;
      else     i_im_araddr = i_im_araddr + 32'h1000;

      for (int c = 0; c <= ar_stall; c++) begin
         i_mem_arready = (c == ar_stall);
         settle();
         check("ar_mem_arvalid", o_mem_arvalid, 1);
         check("ar_araddr", o_mem_araddr, sb[0].addr);
         check("ar_arprot", o_mem_arprot, sb[0].prot);
         check("ar_im_arready", o_im_arready, 0);
         check("ar_dm_arready", o_dm_arready, 0);
         check("ar_grant", o_grant, win);
         tick();
         if (win) i_dm_araddr = i_dm_araddr ^ 32'h0000_0F00;
         else     i_im_araddr = i_im_araddr ^ 32'h0000_0F00;
      end
      i_mem_arready = 1'b0;

      if (win) i_dm_rready = 1'b1;
      else     i_im_rready = 1'b1;
      for (int c = 0; c < rv_wait; c++) begin
         settle();
         check("dw_im_rvalid", o_im_rvalid, 0);
         check("dw_dm_rvalid", o_dm_rvalid, 0);
         check("dw_mem_rready", o_mem_rready, 1);
         check("dw_mem_arvalid", o_mem_arvalid, 0);
         tick();
      end

      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_data(e.addr);
      i_mem_rresp  = resp;
      for (int c = 0; c <= rr_wait; c++) begin
         if (win) i_dm_rready = (c == rr_wait);
         else     i_im_rready = (c == rr_wait);
         settle();
         check("d_im_rvalid", o_im_rvalid, !win);
         check("d_dm_rvalid", o_dm_rvalid, win);
         check("d_mem_rready", o_mem_rready, c == rr_wait);
         check("d_im_arready", o_im_arready, 0);
         check("d_dm_arready", o_dm_arready, 0);
         if (c == rr_wait) begin
            if (sb.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               p = sb.pop_front();
               check("d_port", win, p.port);
               check("d_rdata", win ? o_dm_rdata : o_im_rdata, mem_data(p.addr));
               check("d_rresp", win ? o_dm_rresp : o_im_rresp, p.resp);
            end
         end
         tick();
      end
      i_mem_rvalid = 1'b0;
      i_im_rready  = 1'b0;
      i_dm_rready  = 1'b0;
   endtask

   initial begin
      bit w;
      i_im_araddr = '0;
      i_dm_araddr = '0;
      do_reset();

      // Single fetch at 0x100; data 0x13 goes only to the fetch port.
      i_im_araddr = 32'h0000_0100;
      do_txn(1'b1, 1'b0, 0, 0, 0, 2'b00, 1'b0, w);
      check("single_fetch_owner", w, 0);

      // Simultaneous requests straight after reset: fetch first, then load.
      do_reset();
      i_im_araddr = 32'h0000_0200;
      i_dm_araddr = 32'h8000_0004;
      do_txn(1'b1, 1'b1, 0, 0, 0, 2'b00, 1'b1, w);
      check("tie_first", w, 0);
      do_txn(1'b0, 1'b1, 0, 0, 0, 2'b00, 1'b0, w);
      check("tie_second", w, 1);

      // Both held valid: grants strictly alternate 0,1,0,1,0,1.
      do_reset();
      i_im_araddr = 32'h0000_1000;
      i_dm_araddr = 32'h4000_0000;
      for (int i = 0; i < 6; i++) begin
         do_txn(1'b1, 1'b1, 0, 0, 0, 2'b00, 1'b1, w);
         check("rr_seq", w, i % 2);
      end
      idle_inputs();

      // Memory holds arready low for 3 cycles while fetch changes its address.
      i_im_araddr = 32'h0000_0500;
      do_txn(1'b1, 1'b0, 3, 0, 0, 2'b00, 1'b0, w);

      // Load delays rready 2 cycles while memory data is already valid.
      i_dm_araddr = 32'h8000_0040;
      do_txn(1'b0, 1'b1, 0, 1, 2, 2'b00, 1'b0, w);
      check("rready_wait_owner", w, 1);

      // Reset while in DATA abandons the transaction.
      i_im_araddr  = 32'h0000_0300;
      i_im_arvalid = 1'b1;
      settle();
      check("rd_accept", o_im_arready, 1);
      tick();
      i_im_arvalid  = 1'b0;
      i_mem_arready = 1'b1;
      settle();
      check("rd_addr", o_mem_arvalid, 1);
      tick();
      i_mem_arready = 1'b0;
      i_im_rready   = 1'b1;
      settle();
      check("rd_in_data", o_mem_rready, 1);
      rstn = 1'b0;
      tick();
      i_mem_rvalid = 1'b1;   // a stuck DATA state would leak this to fetch
      settle();
      check("rd_im_rvalid", o_im_rvalid, 0);
      check("rd_dm_rvalid", o_dm_rvalid, 0);
      check("rd_mem_rready", o_mem_rready, 0);
      check("rd_mem_arvalid", o_mem_arvalid, 0);
      rstn = 1'b1;
      exp_last = 1'b1;
      sb.delete();
      idle_inputs();
      i_im_araddr = 32'h0000_0400;
      do_txn(1'b1, 1'b0, 0, 0, 0, 2'b00, 1'b0, w);
      check("post_reset_owner", w, 0);

      // SLVERR passes through unmodified to fetch.
      i_im_araddr = 32'h0000_0600;
      do_txn(1'b1, 1'b0, 0, 0, 0, 2'b10, 1'b0, w);

      // A handful of mixed requests with random stalls.
      for (int i = 0; i < 8; i++) begin
         bit iv, dv;
         iv = $urandom_range(0, 1);
         dv = $urandom_range(0, 1);
         if (!iv && !dv) iv = 1'b1;
         i_im_araddr = $urandom & 32'hFFFF_FFFC;
         i_dm_araddr = $urandom & 32'hFFFF_FFFC;
         do_txn(iv, dv, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 2'($urandom_range(0, 3)), 1'b0, w);
      end

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-to-one read-channel arbiter that shares a single AXI4-Lite style memory read port between instruction fetch and the load path. It sits between the fetch controller's instruction-memory read bus and the data-memory load interface on one side, and the unified memory read port on the other. It allows one outstanding transaction at a time. Grants alternate round-robin when both requesters are active, and each response is routed back to the requester that issued it.

## Interface
- XLEN, 32, address and data width
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- i_im_arvalid  in  1  fetch read-address valid
- o_im_arready  out  1  fetch address accepted
- i_im_araddr  in  XLEN  fetch address
- o_im_rvalid  out  1  fetch read data valid
- i_im_rready  in  1  fetch ready for data
- o_im_rdata  out  XLEN  fetch read data
- o_im_rresp  out  2  fetch response code
- i_dm_arvalid / o_dm_arready / i_dm_araddr / o_dm_rvalid / i_dm_rready / o_dm_rdata / o_dm_rresp: load-path equivalents, same directions and widths
- o_mem_arvalid  out  1  memory address valid
- i_mem_arready  in  1  memory address ready
- o_mem_araddr  out  XLEN  memory address
- o_mem_arprot  out  3  AXI prot; bit2=1 for instruction access, bits1:0=0
- i_mem_rvalid  in  1  memory data valid
- o_mem_rready  out  1  memory data ready
- i_mem_rdata  in  XLEN  memory data
- i_mem_rresp  in  2  memory response
- o_grant  out  1  owner of current transaction: 0=fetch, 1=load; meaningful when state≠IDLE

## Operation
- FSM states: IDLE, ADDR, DATA. State, grant, last-grant, and address/prot registers are the only storage.
- IDLE arbitration, combinational on the arvalids:
  - Only one arvalid high: that requester wins.
  - Both high: the requester not equal to last_grant wins (round-robin).
  - Winner's arready=1 in that cycle, and the handshake completes there. Loser's arready=0.
  - On the handshake, register the address and prot (instr bit = winner is fetch), set grant and last_grant, and go to ADDR.
- ADDR: o_mem_arvalid=1, with araddr/arprot from the registers, held stable until i_mem_arready. On arvalid&arready go to DATA. Both requester arreadys are 0.
- DATA:
  - Granted requester sees rvalid=i_mem_rvalid, rdata=i_mem_rdata, rresp=i_mem_rresp, all combinational.
  - o_mem_rready = granted requester's rready.
  - Non-granted rvalid=0.
  - On i_mem_rvalid&o_mem_rready go to IDLE.
- Response codes pass through unmodified. SLVERR/DECERR are not interpreted.
- The captured address is immune to requester changes after acceptance.
- A requester may drop arvalid without being granted; no state change results.

## Timing
- Reset (rstn=0 at a clock edge) gives:
  - state=IDLE, last_grant=1 (fetch wins the first tie), grant=0, address/prot registers=0.
  - o_mem_arvalid=0, o_mem_rready=0, o_*_rvalid=0.
- Reset mid-transaction (ADDR or DATA) abandons the transaction with no response to the requester. From the next cycle all outputs take their reset values.
- Accept in cycle N (IDLE) gives o_mem_arvalid in N+1. With arready in N+1, DATA is entered in N+2. Data is forwarded with 0 added cycles.
- Minimum occupancy is 3 cycles per transaction (IDLE, ADDR, DATA with immediate rvalid/rready). There is no accept in the DATA→IDLE cycle. Throughput is at most 1 read per 3 cycles.
- Requester arready is asserted only in IDLE and never while a transaction is outstanding.
- With both requesters held continuously valid, grants strictly alternate, giving each a wait of at most one transaction.

## Test plan
- Single fetch, addr 0x0000_0100:
  - im_arready=1 in cycle 0.
  - mem_arvalid with araddr=0x100, arprot=3'b100 in cycle 1.
  - Memory returns 0x0000_0013 resp 0 → o_im_rvalid with rdata 0x13, and o_dm_rvalid stays 0.
- Both arvalid in the same cycle after reset (im 0x200, dm 0x8000_0004):
  - Fetch granted first.
  - Load granted in the next IDLE with arprot=3'b000.
  - Load data reaches only the dm port.
- Both held valid for 6 transactions → grant sequence 0,1,0,1,0,1, with no requester arready while busy.
- i_mem_arready held low 3 cycles in ADDR → o_mem_arvalid stays 1 and araddr stays stable, while the requester changes i_im_araddr.
- i_dm_rready low 2 cycles while i_mem_rvalid=1 → o_mem_rready=0 for 2 cycles and the FSM stays in DATA; the transfer completes on the first rready.
- Two directed cases:
  - rstn low during DATA → next cycle IDLE with all valids 0, and a fresh fetch request is accepted the cycle after rstn rises.
  - Memory rresp=2'b10 → passed through on o_im_rresp.
